// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
//   state_t : flush sequencing states (RUN, FLUSH, SETTLE)
//   rr_next : modulo-m increment of a requester index
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Explicit wrap instead of '%' so non-power-of-2 counts stay cheap.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned m);
        return (idx >= m - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// M-way round-robin priority picker (combinational, no state).
//   req     : request vector
//   en      : global enable; when low no grant is issued
//   ptr     : highest-priority index for this cycle
//   gnt     : one-hot (or zero) grant
//   gnt_idx : index of the granted requester (0 when none)
//   any     : a grant was issued
module rr_arb #(
    parameter int M  = 4,
    parameter int PW = (M > 1) ? $clog2(M) : 1
) (
    input  logic [M-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [M-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        int unsigned pos;
        logic [PW-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = 0;
        sel     = '0;
        // Scan ptr, ptr+1, ... with manual wrap; first hit wins.
        for (int unsigned off = 0; off < M; off++) begin
            pos = 32'(ptr) + off;
            if (pos >= M) pos = pos - M;
            sel = PW'(pos);
            if (en && !any && req[sel]) begin
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter and pop/flush sequencer for one shared FIFO.
//   req/req_data          : M push requesters, data flattened W bits each
//   gnt                   : combinational one-hot grant (data taken this cycle)
//   fifo_push/_data       : FIFO push side
//   fifo_pop/_pop_data    : FIFO pop side
//   fifo_flush            : one-cycle flush strobe
//   fifo_empty_r/_full_r  : registered FIFO status
//   out_valid/data/accept : consumer valid/accept interface
//   flush_req             : flush request (pulse or level)
//   busy                  : flush sequence in progress
module fifo_push_arb
    import fifo_arb_pkg::*;
#(
    parameter int M = 4,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   req,
    input  logic [M*W-1:0] req_data,
    output logic [M-1:0]   gnt,
    output logic           fifo_push,
    output logic [W-1:0]   fifo_push_data,
    output logic           fifo_pop,
    input  logic [W-1:0]   fifo_pop_data,
    output logic           fifo_flush,
    input  logic           fifo_empty_r,
    input  logic           fifo_full_r,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_accept,
    input  logic           flush_req,
    output logic           busy
);

    localparam int PW = (M > 1) ? $clog2(M) : 1;

    if (M < 2) begin : g_bad_m
        $error("fifo_push_arb: M must be >= 2");
    end

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic          arb_en;
    logic          any;
    logic [PW-1:0] gnt_idx;
    logic [W-1:0]  words [M];

    // Reset forces every control output low in the same cycle.
    assign arb_en = !rst && (state == RUN) && !flush_req && !fifo_full_r;

    rr_arb #(.M(M), .PW(PW)) u_rr_arb (
        .req     (req),
        .en      (arb_en),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        for (int unsigned i = 0; i < M; i++) begin
            words[i] = req_data[i*W +: W];
        end
    end

    assign fifo_push      = any;
    assign fifo_push_data = words[gnt_idx];

    assign out_valid  = !rst && (state == RUN) && !flush_req && !fifo_empty_r;
    assign fifo_pop   = out_valid && out_accept;
    assign out_data   = fifo_pop_data;
    assign fifo_flush = !rst && (state == FLUSH);
    assign busy       = !rst && (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            rr_ptr <= '0;
        end else begin
            if (any) rr_ptr <= PW'(rr_next(32'(gnt_idx), M));
            case (state)
                RUN:     if (flush_req) state <= FLUSH;
                FLUSH:   state <= SETTLE;
                SETTLE:  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    a_gnt_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full_r));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(fifo_pop && fifo_empty_r));
    a_flush_quiet:  assert property (@(posedge clk) disable iff (rst) fifo_flush |-> (!fifo_push && !fifo_pop));

endmodule

// File: tb/tb_fifo_push_arb.sv
module tb_fifo_push_arb;

    localparam int M = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [M-1:0]   req;
    logic [M*W-1:0] req_data;
    logic [M-1:0]   gnt;
    logic           fifo_push;
    logic [W-1:0]   fifo_push_data;
    logic           fifo_pop;
    logic [W-1:0]   fifo_pop_data;
    logic           fifo_flush;
    logic           fifo_empty_r;
    logic           fifo_full_r;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_accept;
    logic           flush_req;
    logic           busy;

    int ntests = 0;
    int nfail  = 0;

    // Reference model: next preferred requester and flush phase
    // (0 = normal operation, 1 = flush strobe cycle, 2 = settle cycle).
    int m_ptr   = 0;
    int m_phase = 0;

    fifo_push_arb #(.M(M), .W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .gnt            (gnt),
        .fifo_push      (fifo_push),
        .fifo_push_data (fifo_push_data),
        .fifo_pop       (fifo_pop),
        .fifo_pop_data  (fifo_pop_data),
        .fifo_flush     (fifo_flush),
        .fifo_empty_r   (fifo_empty_r),
        .fifo_full_r    (fifo_full_r),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_accept     (out_accept),
        .flush_req      (flush_req),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs against the model for the current inputs, then
    // advance one clock and update the model from the same inputs.
    task automatic cycle();
        logic [M-1:0] eg;
        int g;
        logic run, arb, ev;
        #1;
        run = !rst && (m_phase == 0);
        arb = run && !flush_req && !fifo_full_r;
        eg  = '0;
        g   = -1;
        if (arb) begin
            for (int k = 0; k < M; k++) begin
                int i;
                i = (m_ptr + k) % M;
                if (g < 0 && req[i]) g = i;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        ev = run && !flush_req && !fifo_empty_r;
        chk("gnt",        W'(gnt),        W'(eg));
        chk("fifo_push",  W'(fifo_push),  W'(g >= 0));
        if (g >= 0) chk("push_data", fifo_push_data, req_data[g*W +: W]);
        chk("out_valid",  W'(out_valid),  W'(ev));
        chk("fifo_pop",   W'(fifo_pop),   W'(ev && out_accept));
        chk("out_data",   out_data,       fifo_pop_data);
        chk("fifo_flush", W'(fifo_flush), W'(!rst && m_phase == 1));
        chk("busy",       W'(busy),       W'(!rst && m_phase != 0));
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
        end else begin
            if (g >= 0) m_ptr = (g + 1) % M;
            case (m_phase)
                0:       if (flush_req) m_phase = 1;
                1:       m_phase = 2;
                default: m_phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < M; i++) req_data[i*W +: W] = $urandom;
        fifo_pop_data = $urandom;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; fifo_pop_data = '0;
        fifo_empty_r = 1'b1; fifo_full_r = 1'b0; out_accept = 1'b0; flush_req = 1'b0;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;

        // Idle after reset.
        #1;
        chk("idle_gnt",   W'(gnt),        '0);
        chk("idle_valid", W'(out_valid),  '0);
        chk("idle_busy",  W'(busy),       '0);
        chk("idle_flush", W'(fifo_flush), '0);
        cycle();

        // Full contention: 0001,0010,0100,1000,0001,...
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            logic [M-1:0] want;
            rand_data();
            want = 4'b0001 << (n % 4);
            #1;
            chk("contend_gnt", W'(gnt), W'(want));
            cycle();
        end

        // Skip and wrap: grant 1 once so pointer sits at 2.
        req = 4'b0010; cycle();
        req = 4'b0011;
        #1; chk("skip_gnt0", W'(gnt), W'(4'b0001)); cycle();
        #1; chk("skip_gnt1", W'(gnt), W'(4'b0010)); cycle();

        // Backpressure: full holds the grant and the pointer.
        req = 4'b0100; fifo_full_r = 1'b1;
        #1; chk("full_gnt", W'(gnt), '0); cycle();
        cycle();
        fifo_full_r = 1'b0;
        #1; chk("unfull_gnt", W'(gnt), W'(4'b0100)); cycle();

        // Flush with traffic pending.
        req = 4'b1000; fifo_empty_r = 1'b0; out_accept = 1'b1; flush_req = 1'b1;
        #1;
        chk("flreq_gnt", W'(gnt),      '0);
        chk("flreq_pop", W'(fifo_pop), '0);
        cycle();
        flush_req = 1'b0;
        #1;
        chk("flush_strobe", W'(fifo_flush), W'(1'b1));
        chk("flush_busy",   W'(busy),       W'(1'b1));
        cycle();
        fifo_empty_r = 1'b1;
        #1; chk("settle_valid", W'(out_valid), '0); cycle();
        #1;
        chk("resume_gnt",   W'(gnt),       W'(4'b1000));
        chk("resume_valid", W'(out_valid), '0);
        cycle();

        // Reset during the flush strobe cycle.
        req = '0; flush_req = 1'b1; cycle();
        flush_req = 1'b0; rst = 1'b1;
        #1; chk("rst_flush", W'(fifo_flush), '0); cycle();
        rst = 1'b0; req = 4'b1111;
        #1;
        chk("rst_busy", W'(busy), '0);
        chk("rst_ptr",  W'(gnt),  W'(4'b0001));
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rand_data();
            req          = M'($urandom);
            fifo_full_r  = ($urandom_range(0, 3) == 0);
            fifo_empty_r = ($urandom_range(0, 2) == 0);
            out_accept   = $urandom_range(0, 1) == 1;
            flush_req    = ($urandom_range(0, 11) == 0);
            rst          = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arb.md
Name: fifo_push_arb

Overview:
- Round-robin controller that shares one fifo_basic instance among M push requesters and drives its pop side from a valid/accept consumer.
- Sequences FIFO flush through a small FSM so that no push or pop is issued around the flush.
- Sits between producer clients and an external fifo_basic. Only the FIFO control/status ports connect to this block.

Parameters:
- M, 4, number of requesters; must be >= 2; need not be a power of 2.
- W, 32, data word width; must match the FIFO's W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-high, one clock.
- req  in  M  per-requester push request; held with data until granted.
- req_data  in  M*W  flattened request data; requester i occupies bits [i*W +: W].
- gnt  out  M  one-hot/zero grant (combinational); data is accepted this cycle.
- fifo_push  out  1  FIFO push strobe.
- fifo_push_data  out  W  FIFO push data.
- fifo_pop  out  1  FIFO pop strobe.
- fifo_pop_data  in  W  FIFO head data.
- fifo_flush  out  1  FIFO flush strobe.
- fifo_empty_r  in  1  FIFO empty status (registered).
- fifo_full_r  in  1  FIFO full status (registered).
- out_valid  out  1  head word available to consumer.
- out_data  out  W  head word (fifo_pop_data passthrough).
- out_accept  in  1  consumer takes head word this cycle.
- flush_req  in  1  request a FIFO flush (single-cycle pulse or level).
- busy  out  1  flush sequence in progress.

Behaviour:
- Registered state: FSM state in {RUN, FLUSH, SETTLE} and rr_ptr[$clog2(M)-1:0].
- Reset values: state=RUN, rr_ptr=0.
- All outputs are combinational from state, rr_ptr and inputs. With rst asserted they are all 0, except out_data, which passes through.
- Arbitration enable: arb_en = (state==RUN) & ~flush_req & ~fifo_full_r.
- Grant selection: gnt[i]=1 for the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod M. gnt=0 if arb_en=0 or req=0.
- Push path: fifo_push = |gnt. fifo_push_data = req_data slice of the granted index; value is don't-care when gnt=0. Zero-cycle latency from grant to push.
- rr_ptr update: on any grant to index i, rr_ptr <= (i+1) mod M, with explicit wrap from M-1 to 0. No update when gnt=0.
- Fairness bound: a held request is granted within M grant cycles.
- Pop path:
  - out_valid = (state==RUN) & ~flush_req & ~fifo_empty_r.
  - fifo_pop = out_valid & out_accept.
  - out_data = fifo_pop_data.
- Simultaneous push and pop in RUN are both allowed. Push is gated only by full, pop only by empty.
- FSM transitions:
  - RUN: flush_req=1 -> FLUSH. In that cycle no grant and no pop (flush has priority over same-cycle traffic).
  - FLUSH: fifo_flush=1 for exactly this cycle; gnt=0, fifo_pop=0, out_valid=0; -> SETTLE unconditionally.
  - SETTLE: gnt=0, out_valid=0, lets the FIFO status flops reflect the flush; -> RUN unconditionally.
- busy = (state!=RUN).
- flush_req while busy is ignored; a level-held flush_req re-triggers on the first RUN cycle.
- rr_ptr is retained across a flush.
- Reset mid-flush: state returns to RUN and fifo_flush deasserts the same cycle rst is high. The FIFO reset restores empty.
- Contract assertions (libtb2):
  - $onehot0(gnt).
  - !(fifo_push & fifo_full_r).
  - !(fifo_pop & fifo_empty_r).
  - fifo_flush implies !fifo_push & !fifo_pop.
  - Static assert M >= 2.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state_t enum {RUN, FLUSH, SETTLE};
  - helper function rr_next(idx, M) (mod-M increment).
- One natural sub-module: rr_arb, a parameterised M-way round-robin priority picker.
  - Inputs: req, en, ptr.
  - Outputs: gnt one-hot, gnt_idx, any.
  - Pointer register lives in the parent.
- fifo_basic is instantiated by the integrating level, not inside this block.

Test Plan:
- Reset, then idle: req=0, fifo_empty_r=1 -> gnt=0, out_valid=0, busy=0, fifo_flush=0.
- Contention: M=4, req=4'b1111 held 8 cycles, FIFO not full, rr_ptr=0 -> gnt sequence 0001,0010,0100,1000,0001,... and rr_ptr wraps 3->0.
- Skip and wrap: rr_ptr=2, req=4'b0011 -> gnt=0001, rr_ptr becomes 1. Next cycle gnt=0010, rr_ptr becomes 2.
- Backpressure: fifo_full_r=1 with req=4'b0100 -> gnt=0, rr_ptr unchanged. Full drops -> gnt=0100 the same cycle.
- Flush with traffic:
  - Stimulus: FIFO holding 3 words, req=4'b1000, out_accept=1, flush_req pulse.
  - That cycle: gnt=0, fifo_pop=0.
  - Next cycle: fifo_flush=1, busy=1.
  - Then SETTLE: out_valid=0.
  - Then RUN resumes: gnt=1000, out_valid=0 until the pushed word is visible.
- Reset asserted in FLUSH -> fifo_flush=0 that cycle, next state RUN, rr_ptr=0.
